// File: rtl/pipe_sched_pkg.sv
// rtl/pipe_sched_pkg.sv - shared constants for the pipeline stall/flush scheduler
package pipe_sched_pkg;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NOSTOP     = 1'b0;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MADD2    = 2'd1;
    localparam logic [1:0] S_DIV_WAIT = 2'd2;

    localparam logic [5:0] MASK_NONE = 6'b000000;
    localparam logic [5:0] MASK_IF   = 6'b000011;
    localparam logic [5:0] MASK_ID   = 6'b000111;
    localparam logic [5:0] MASK_EX   = 6'b001111;

    localparam logic [5:0]  DIV_CNT_MAX = 6'd63;
    localparam logic [31:0] EXC_VECTOR  = 32'h0000_0020;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    function automatic logic [31:0] exc_target(input logic [31:0] excepttype,
                                               input logic [31:0] epc);
        if (excepttype == EXC_ERET)
            return epc;
        else
            return EXC_VECTOR;
    endfunction

endpackage

// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - stall/flush scheduler with madd second-cycle and divider wait FSM
module pipe_sched
    import pipe_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        madd_req_i,
    input  logic        div_start_i,
    input  logic        div_ready_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic        madd_second_o,
    output logic        div_err_o
);

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic        r_div_err;

    logic [1:0]  w_state_nxt;
    logic [5:0]  w_cnt_nxt;
    logic        w_div_err_nxt;
    logic [5:0]  w_fsm_mask;
    logic [5:0]  w_ext_mask;
    logic        w_exc;
    logic        w_div_start;
    logic        w_div_cancel;
    logic        w_madd_second;

    assign w_exc = (excepttype_i != 32'h0);

    always_comb begin
        w_ext_mask = MASK_NONE;
        if (stallreq_from_if == STOP) w_ext_mask = w_ext_mask | MASK_IF;
        if (stallreq_from_id == STOP) w_ext_mask = w_ext_mask | MASK_ID;
        if (stallreq_from_ex == STOP) w_ext_mask = w_ext_mask | MASK_EX;
    end

    // An exception overrides the FSM: it drops back to IDLE, cancelling any divide in flight.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_div_err_nxt = r_div_err;
        w_fsm_mask    = MASK_NONE;
        w_div_start   = 1'b0;
        w_div_cancel  = 1'b0;
        w_madd_second = 1'b0;
        if (w_exc) begin
            w_state_nxt  = S_IDLE;
            w_div_cancel = (r_state == S_DIV_WAIT);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (madd_req_i) begin
                        w_fsm_mask  = MASK_EX;
                        w_state_nxt = S_MADD2;
                    end else if (div_start_i) begin
                        w_fsm_mask  = MASK_EX;
                        w_div_start = 1'b1;
                        w_cnt_nxt   = 6'd0;
                        w_state_nxt = S_DIV_WAIT;
                    end
                end
                S_MADD2: begin
                    w_madd_second = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
                S_DIV_WAIT: begin
                    // Ready wins over a coinciding timeout, so no error is flagged then.
                    if (div_ready_i) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == DIV_CNT_MAX) begin
                        w_div_cancel  = 1'b1;
                        w_div_err_nxt = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_fsm_mask = MASK_EX;
                        w_cnt_nxt  = r_cnt + 6'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_div_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div_err <= w_div_err_nxt;
        end
    end

    always_comb begin
        stall         = MASK_NONE;
        flush         = 1'b0;
        new_pc        = 32'h0;
        div_start_o   = 1'b0;
        div_cancel_o  = 1'b0;
        madd_second_o = 1'b0;
        if (rst != RST_ENABLE) begin
            div_start_o   = w_div_start;
            div_cancel_o  = w_div_cancel;
            madd_second_o = w_madd_second;
            if (w_exc) begin
                flush  = 1'b1;
                new_pc = exc_target(excepttype_i, cp0_epc_i);
            end else begin
                stall = w_fsm_mask | w_ext_mask;
            end
        end
    end

    assign div_err_o = r_div_err;

endmodule

// File: tb/tb_pipe_sched.sv
// tb/tb_pipe_sched.sv - randomized and directed self-checking bench for pipe_sched
module tb_pipe_sched;

    logic        clk;
    logic        rst;
    logic        stallreq_from_if, stallreq_from_id, stallreq_from_ex;
    logic        madd_req_i, div_start_i, div_ready_i;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_start_o, div_cancel_o, madd_second_o, div_err_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    pipe_sched dut (
        .clk(clk), .rst(rst),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_id(stallreq_from_id),
        .stallreq_from_ex(stallreq_from_ex), .madd_req_i(madd_req_i),
        .div_start_i(div_start_i), .div_ready_i(div_ready_i),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .div_start_o(div_start_o), .div_cancel_o(div_cancel_o),
        .madd_second_o(madd_second_o), .div_err_o(div_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a madd owes one follow-up cycle; a divide has waited some number of cycles.
    bit m_madd_owed  = 0;
    bit m_div_busy   = 0;
    int m_div_waited = 0;
    bit m_err        = 0;

    always @(negedge clk) begin : model_check
        logic [5:0]  e_stall;
        logic        e_flush, e_start, e_cancel, e_second;
        logic [31:0] e_pc;
        e_stall = 0; e_flush = 0; e_pc = 0; e_start = 0; e_cancel = 0; e_second = 0;
        if (chk_en) begin
            if (!rst) begin
                m_madd_owed = 0; m_div_busy = 0; m_div_waited = 0;
            end else if (excepttype_i != 0) begin
                e_flush  = 1;
                e_pc     = (excepttype_i == 32'he) ? cp0_epc_i : 32'h20;
                e_cancel = m_div_busy;
                m_madd_owed = 0; m_div_busy = 0;
            end else begin
                if (m_madd_owed) begin
                    e_second = 1;
                    m_madd_owed = 0;
                end else if (m_div_busy) begin
                    if (div_ready_i) begin
                        m_div_busy = 0;
                    end else if (m_div_waited == 63) begin
                        e_cancel = 1;
                        m_div_busy = 0;
                    end else begin
                        e_stall = 6'd15;
                        m_div_waited++;
                    end
                end else if (madd_req_i) begin
                    e_stall = 6'd15;
                    m_madd_owed = 1;
                end else if (div_start_i) begin
                    e_stall = 6'd15;
                    e_start = 1;
                    m_div_busy = 1;
                    m_div_waited = 0;
                end
                if (stallreq_from_if) e_stall = e_stall | 6'd3;
                if (stallreq_from_id) e_stall = e_stall | 6'd7;
                if (stallreq_from_ex) e_stall = e_stall | 6'd15;
            end
            n_checks++;
            if ({stall, flush, new_pc, div_start_o, div_cancel_o, madd_second_o, div_err_o} ===
                {e_stall, e_flush, e_pc, e_start, e_cancel, e_second, m_err})
                n_pass++;
            else
                $display("FAIL model t=%0t: got stall=%b flush=%b pc=%h start=%b cancel=%b second=%b err=%b, required stall=%b flush=%b pc=%h start=%b cancel=%b second=%b err=%b",
                         $time, stall, flush, new_pc, div_start_o, div_cancel_o, madd_second_o, div_err_o,
                         e_stall, e_flush, e_pc, e_start, e_cancel, e_second, m_err);
            if (!rst) m_err = 0;
            else if (e_cancel && excepttype_i == 0) m_err = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        stallreq_from_if = 0; stallreq_from_id = 0; stallreq_from_ex = 0;
        madd_req_i = 0; div_start_i = 0; div_ready_i = 0;
        excepttype_i = 0; cp0_epc_i = 0;
    endtask

    initial begin : stim
        int stalled;
        int found;
        idle_inputs();
        rst = 0;
        chk_en = 1;

        repeat (2) begin
            mid();
            chk("rst_stall", {26'h0, stall}, 0);
            chk("rst_flush", {31'h0, flush}, 0);
            chk("rst_err", {31'h0, div_err_o}, 0);
            nxt();
        end
        rst = 1;
        mid(); chk("post_rst_stall", {26'h0, stall}, 0); chk("post_rst_err", {31'h0, div_err_o}, 0); nxt();

        madd_req_i = 1;
        mid(); chk("madd1_stall", {26'h0, stall}, 32'h0f); nxt();
        mid(); chk("madd2_second", {31'h0, madd_second_o}, 1); chk("madd2_stall", {26'h0, stall}, 0); nxt();
        madd_req_i = 0;

        div_start_i = 1;
        mid(); chk("div_start_pulse", {31'h0, div_start_o}, 1); nxt();
        div_start_i = 0;
        stalled = 1;
        repeat (33) begin
            mid();
            if (stall == 6'h0f && !div_start_o) stalled++;
            nxt();
        end
        div_ready_i = 1;
        mid(); chk("div_ready_stall", {26'h0, stall}, 0); nxt();
        div_ready_i = 0;
        chk("div34_stall_cycles", stalled, 34);

        div_start_i = 1;
        mid(); nxt();
        div_start_i = 0;
        found = -1;
        for (int i = 1; i <= 100 && found < 0; i++) begin
            mid();
            if (div_cancel_o) begin
                found = i;
                chk("timeout_err_same", {31'h0, div_err_o}, 0);
            end
            nxt();
        end
        chk("timeout_latency", found, 64);
        mid(); chk("timeout_err_next", {31'h0, div_err_o}, 1); chk("timeout_stall", {26'h0, stall}, 0); nxt();
        madd_req_i = 1;
        mid(); chk("after_timeout_idle", {26'h0, stall}, 32'h0f); nxt();
        madd_req_i = 0;
        mid(); nxt();

        div_start_i = 1;
        mid(); nxt();
        div_start_i = 0;
        repeat (5) begin mid(); nxt(); end
        excepttype_i = 32'he; cp0_epc_i = 32'h100;
        mid();
        chk("eret_flush", {31'h0, flush}, 1);
        chk("eret_pc", new_pc, 32'h100);
        chk("eret_stall", {26'h0, stall}, 0);
        chk("eret_cancel", {31'h0, div_cancel_o}, 1);
        nxt();
        idle_inputs();
        mid(); chk("post_exc_cancel", {31'h0, div_cancel_o}, 0); chk("post_exc_stall", {26'h0, stall}, 0); nxt();

        stallreq_from_if = 1; stallreq_from_id = 1;
        mid(); chk("merge_stall", {26'h0, stall}, 32'h07); nxt();
        excepttype_i = 32'h8;
        mid();
        chk("exc_flush", {31'h0, flush}, 1);
        chk("exc_pc", new_pc, 32'h20);
        chk("exc_stall", {26'h0, stall}, 0);
        nxt();
        idle_inputs();

        madd_req_i = 1; div_start_i = 1;
        mid(); chk("prio_no_div", {31'h0, div_start_o}, 0); chk("prio_stall", {26'h0, stall}, 32'h0f); nxt();
        madd_req_i = 0; div_start_i = 0;
        mid(); chk("prio_second", {31'h0, madd_second_o}, 1); nxt();

        rst = 0;
        mid(); nxt();
        rst = 1; div_start_i = 1;
        mid(); nxt();
        div_start_i = 0;
        repeat (63) begin mid(); nxt(); end
        div_ready_i = 1;
        mid(); chk("ready_at_max_cancel", {31'h0, div_cancel_o}, 0); chk("ready_at_max_stall", {26'h0, stall}, 0); nxt();
        div_ready_i = 0;
        mid(); chk("ready_at_max_err", {31'h0, div_err_o}, 0); nxt();

        div_start_i = 1;
        mid(); nxt();
        div_start_i = 0;
        repeat (10) begin mid(); nxt(); end
        rst = 0;
        mid(); chk("rst_in_div_cancel", {31'h0, div_cancel_o}, 0); chk("rst_in_div_stall", {26'h0, stall}, 0); nxt();
        rst = 1;
        mid(); chk("rst_in_div_idle", {26'h0, stall}, 0); nxt();

        repeat (3000) begin
            rst              = ($urandom_range(0, 199) != 0);
            stallreq_from_if = ($urandom_range(0, 5) == 0);
            stallreq_from_id = ($urandom_range(0, 5) == 0);
            stallreq_from_ex = ($urandom_range(0, 7) == 0);
            madd_req_i       = ($urandom_range(0, 7) == 0);
            div_start_i      = ($urandom_range(0, 5) == 0);
            div_ready_i      = ($urandom_range(0, 59) == 0);
            cp0_epc_i        = $urandom;
            case ($urandom_range(0, 59))
                0:       excepttype_i = 32'he;
                1:       excepttype_i = 32'h8;
                2:       excepttype_i = $urandom | 32'h1;
                default: excepttype_i = 32'h0;
            endcase
            mid();
            nxt();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
